// File: rtl/adc_sample_averager.sv
// ---------------------------------------------------------------------------
// adc_sample_averager
//
// Averages 2**LOG2_AVG consecutive SAR conversion results into one output
// word and offers it on a valid/ready handshake. A sample is taken on the
// rising edge of in_valid, so a level held high counts once. When a new
// average completes while the previous one is still waiting for the
// consumer, the new average is dropped and the sticky overrun flag is set.
//
// Parameters
//   DATA_W    width of the SAR result and of the averaged output
//   LOG2_AVG  log2 of samples per average, legal 0..4 (0 = pass-through)
//
// Ports
//   clk        system clock, shared with the SAR control stage
//   rst_n      asynchronous reset, active low
//   en         1 = accumulate; 0 = idle with the partial sum discarded
//   clr        synchronous clear of accumulator, output word and overrun
//   in_result  SAR conversion result
//   in_valid   SAR valid level; each rising edge is one sample
//   out_data   averaged result (registered)
//   out_valid  out_data holds an average not yet accepted (registered)
//   out_ready  consumer accepts out_data when out_valid & out_ready
//   overrun    sticky flag: at least one average was dropped (registered)
// ---------------------------------------------------------------------------
module adc_sample_averager #(
  parameter int DATA_W   = 8,
  parameter int LOG2_AVG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  // Sum of 2**LOG2_AVG samples of DATA_W bits always fits in ACC_W bits.
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int N     = 32'd1 << LOG2_AVG;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   acc_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               in_valid_q_r;
  logic [DATA_W-1:0]  out_data_r;
  logic [DATA_W-1:0]  out_data_nxt_s;
  logic               out_valid_r;
  logic               out_valid_nxt_s;
  logic               overrun_r;
  logic               overrun_nxt_s;

  logic               stb_s;
  logic               accept_s;
  logic               last_s;
  logic [ACC_W-1:0]   sum_s;
  logic [DATA_W-1:0]  avg_s;

  // Sample strobe, handshake acceptance and the running sum including the current sample.
  always_comb begin
    stb_s    = in_valid & ~in_valid_q_r;
    accept_s = out_valid_r & out_ready;
    // With LOG2_AVG=0 the counter is a constant 0 and every sample is the last one.
    last_s   = (cnt_r == CNT_W'(N - 32'd1));
    sum_s    = acc_r + ACC_W'(in_result);
    // Divide by 2**LOG2_AVG by keeping the top DATA_W bits (truncation, no rounding).
    avg_s    = sum_s[ACC_W-1:LOG2_AVG];
  end

  // FSM next state: the mode simply tracks en, independent of clr.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (en) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath next state: accumulation, average completion, handshake and overrun.
  always_comb begin
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    overrun_nxt_s   = overrun_r;

    if (clr) begin
      // Clear wins over everything, including a strobe in the same cycle.
      acc_nxt_s       = {ACC_W{1'b0}};
      cnt_nxt_s       = {CNT_W{1'b0}};
      out_data_nxt_s  = {DATA_W{1'b0}};
      out_valid_nxt_s = 1'b0;
      overrun_nxt_s   = 1'b0;
    end else begin
      // Acceptance retires the word; a completion below may re-raise valid.
      if (accept_s) begin
        out_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s = out_valid_r;
      end

      case (state_r)
        ST_IDLE: begin
          acc_nxt_s = {ACC_W{1'b0}};
          cnt_nxt_s = {CNT_W{1'b0}};
        end
        ST_ACCUM: begin
          if (!en) begin
            // Leaving ACCUM: the partial sum is thrown away.
            acc_nxt_s = {ACC_W{1'b0}};
            cnt_nxt_s = {CNT_W{1'b0}};
          end else if (stb_s) begin
            if (last_s) begin
              acc_nxt_s = {ACC_W{1'b0}};
              cnt_nxt_s = {CNT_W{1'b0}};
              if (!out_valid_r || accept_s) begin
                out_data_nxt_s  = avg_s;
                out_valid_nxt_s = 1'b1;
              end else begin
                // Previous word still pending: drop this average, keep out_data stable.
                overrun_nxt_s = 1'b1;
              end
            end else begin
              acc_nxt_s = sum_s;
              cnt_nxt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            acc_nxt_s = acc_r;
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          acc_nxt_s = {ACC_W{1'b0}};
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers; in_valid_q tracks in_valid in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      acc_r        <= {ACC_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      in_valid_q_r <= 1'b0;
      out_data_r   <= {DATA_W{1'b0}};
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      acc_r        <= acc_nxt_s;
      cnt_r        <= cnt_nxt_s;
      in_valid_q_r <= in_valid;
      out_data_r   <= out_data_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      overrun_r    <= overrun_nxt_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule
